// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle multiply/divide unit owning the HI/LO pair.
// Sign handling wraps an unsigned shift-add / restoring-division engine that
// runs WIDTH iterations. The quotient and remainder share the 2*WIDTH
// accumulator with the product.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             MTHI,
    input  logic             MTLO,
    input  logic [WIDTH-1:0] WrData,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;      // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   r_opb;      // multiplicand or divisor magnitude
    logic               r_is_div;
    logic               r_neg_q;    // operand signs differ (signed ops only)
    logic               r_neg_r;    // dividend negative (signed ops only)
    logic               r_divzero;
    logic               r_done;
    logic               r_divz_pulse;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_nxt;
    logic [WIDTH:0]     w_div_rem;
    logic [WIDTH-1:0]   w_div_diff;
    logic               w_div_ge;
    logic [2*WIDTH-1:0] w_div_nxt;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // State register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: divide-by-zero skips CALC and goes straight to FIX
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    if (Op[1] && (B == '0)) begin
                        w_state_nxt = S_FIX;
                    end else begin
                        w_state_nxt = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (r_cnt == LAST) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        Busy = (r_state != S_IDLE);
    end

    // Operand magnitudes, one engine step for each operation, and sign correction
    always_comb begin
        w_a_abs = (Op[0] && A[WIDTH-1]) ? -A : A;
        w_b_abs = (Op[0] && B[WIDTH-1]) ? -B : B;

        w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
        w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

        w_div_rem  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_div_ge   = (w_div_rem >= {1'b0, r_opb});
        w_div_diff = w_div_rem[WIDTH-1:0] - r_opb;
        w_div_nxt  = {(w_div_ge ? w_div_diff : w_div_rem[WIDTH-1:0]),
                      r_acc[WIDTH-2:0], w_div_ge};

        w_prod_fix = r_neg_q ? -r_acc : r_acc;
        w_quot_fix = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem_fix  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    end

    // Datapath: capture on Start, iterate in CALC, commit HI/LO in FIX, MTHI/MTLO in IDLE
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_cnt        <= '0;
            r_acc        <= '0;
            r_opb        <= '0;
            r_is_div     <= 1'b0;
            r_neg_q      <= 1'b0;
            r_neg_r      <= 1'b0;
            r_divzero    <= 1'b0;
            r_done       <= 1'b0;
            r_divz_pulse <= 1'b0;
            r_hi         <= '0;
            r_lo         <= '0;
        end else begin
            r_done       <= 1'b0;
            r_divz_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_cnt     <= '0;
                        r_acc     <= {{WIDTH{1'b0}}, w_a_abs};
                        r_opb     <= w_b_abs;
                        r_is_div  <= Op[1];
                        r_neg_q   <= Op[0] && (A[WIDTH-1] ^ B[WIDTH-1]);
                        r_neg_r   <= Op[0] && A[WIDTH-1];
                        r_divzero <= Op[1] && (B == '0);
                    end else begin
                        if (MTHI) begin
                            r_hi <= WrData;
                        end
                        if (MTLO) begin
                            r_lo <= WrData;
                        end
                    end
                end
                S_CALC: begin
                    r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
                    r_cnt <= r_cnt + CW'(1);
                end
                S_FIX: begin
                    r_done       <= 1'b1;
                    r_divz_pulse <= r_divzero;
                    r_divzero    <= 1'b0;
                    if (!r_divzero) begin
                        if (r_is_div) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quot_fix;
                        end else begin
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Done    = r_done;
    assign DivZero = r_divz_pulse;
    assign HI      = r_hi;
    assign LO      = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed testbench for muldiv_sequencer: table of arithmetic vectors plus
// hand-written sequences for divide-by-zero, ignored requests while busy,
// MTHI/MTLO and mid-operation reset.
module tb_muldiv_sequencer;

    localparam int unsigned WIDTH = 32;

    logic             Clk;
    logic             Reset;
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             MTHI;
    logic             MTLO;
    logic [WIDTH-1:0] WrData;
    logic             Busy;
    logic             Done;
    logic             DivZero;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    int unsigned n_checks;
    int unsigned n_errors;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs [9];

    muldiv_sequencer #(.WIDTH(WIDTH)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .Op      (Op),
        .A       (A),
        .B       (B),
        .MTHI    (MTHI),
        .MTLO    (MTLO),
        .WrData  (WrData),
        .Busy    (Busy),
        .Done    (Done),
        .DivZero (DivZero),
        .HI      (HI),
        .LO      (LO)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge inside cycle 'start_cycle' after the Start edge.
    task automatic wait_done(input string name, input int unsigned start_cycle,
                             input int unsigned exp_lat, input logic exp_dz,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int unsigned cycles;
        int unsigned busy_cycles;
        cycles = start_cycle;
        busy_cycles = start_cycle - 1;
        while (Done !== 1'b1 && cycles < 200) begin
            if (Busy === 1'b1) busy_cycles++;
            @(negedge Clk);
            cycles++;
        end
        check({name, " done latency"}, cycles, exp_lat);
        check({name, " busy cycles"}, busy_cycles, exp_lat - 1);
        check({name, " busy at done"}, {31'b0, Busy}, 32'd0);
        check({name, " divzero"}, {31'b0, DivZero}, {31'b0, exp_dz});
        check({name, " HI"}, HI, exp_hi);
        check({name, " LO"}, LO, exp_lo);
        @(negedge Clk);
        check({name, " done pulse width"}, {31'b0, Done}, 32'd0);
        check({name, " divzero pulse width"}, {31'b0, DivZero}, 32'd0);
    endtask

    task automatic run_op(input string name, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic exp_dz, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        @(negedge Clk);
        Start = 1'b1; Op = op; A = a; B = b;
        @(negedge Clk);
        Start = 1'b0; A = '0; B = '0;
        wait_done(name, 1, exp_dz ? 2 : WIDTH + 2, exp_dz, exp_hi, exp_lo);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        Reset = 1'b0; Start = 1'b0; Op = 2'b00; A = '0; B = '0;
        MTHI = 1'b0; MTLO = 1'b0; WrData = '0;

        vecs[0] = '{"multu max",     2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{"mult -3*7",     2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2] = '{"mult -3*-7",    2'b01, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'h00000000, 32'h00000015};
        vecs[3] = '{"mult min*min",  2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[4] = '{"divu 100/7",    2'b10, 32'd100,      32'd7,        32'h00000002, 32'h0000000E};
        vecs[5] = '{"div -7/2",      2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[6] = '{"div 7/-2",      2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[7] = '{"div overflow",  2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[8] = '{"divu max/16",   2'b10, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};

        // Reset state
        repeat (3) @(negedge Clk);
        check("reset Busy",    {31'b0, Busy},    32'd0);
        check("reset Done",    {31'b0, Done},    32'd0);
        check("reset DivZero", {31'b0, DivZero}, 32'd0);
        check("reset HI", HI, 32'd0);
        check("reset LO", LO, 32'd0);
        Reset = 1'b1;

        // Arithmetic vectors
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, vecs[i].hi, vecs[i].lo);
        end

        // Preload via MTHI/MTLO, then divide by zero leaves them intact
        @(negedge Clk); MTHI = 1'b1; WrData = 32'h11;
        @(negedge Clk); MTHI = 1'b0; MTLO = 1'b1; WrData = 32'h22;
        @(negedge Clk); MTLO = 1'b0;
        check("preload HI", HI, 32'h11);
        check("preload LO", LO, 32'h22);
        run_op("divu by zero", 2'b10, 32'd5, 32'd0, 1'b1, 32'h11, 32'h22);
        run_op("div by zero", 2'b11, 32'hFFFFFFFB, 32'd0, 1'b1, 32'h11, 32'h22);

        // MTHI and new Start during Busy are ignored
        @(negedge Clk); Start = 1'b1; Op = 2'b00; A = 32'd3; B = 32'd4;
        @(negedge Clk); Start = 1'b0; A = '0; B = '0;
        @(negedge Clk);
        MTHI = 1'b1; WrData = 32'h1234; Start = 1'b1; Op = 2'b01; A = 32'd5; B = 32'd5;
        @(negedge Clk);
        MTHI = 1'b0; Start = 1'b0; A = '0; B = '0;
        check("mthi while busy", HI, 32'h11);
        wait_done("busy ignore", 3, WIDTH + 2, 1'b0, 32'h0, 32'hC);

        // MTLO in IDLE, visible next cycle
        @(negedge Clk); MTLO = 1'b1; WrData = 32'hABCD;
        @(negedge Clk); MTLO = 1'b0;
        check("mtlo idle LO", LO, 32'hABCD);
        check("mtlo idle HI", HI, 32'h0);

        // Simultaneous MTHI/MTLO write both registers
        @(negedge Clk); MTHI = 1'b1; MTLO = 1'b1; WrData = 32'h5A5A;
        @(negedge Clk); MTHI = 1'b0; MTLO = 1'b0;
        check("mthi+mtlo HI", HI, 32'h5A5A);
        check("mthi+mtlo LO", LO, 32'h5A5A);

        // Start with MTHI in IDLE: Start wins
        @(negedge Clk); Start = 1'b1; Op = 2'b00; A = 32'd2; B = 32'd2; MTHI = 1'b1; WrData = 32'h77;
        @(negedge Clk); Start = 1'b0; MTHI = 1'b0; A = '0; B = '0;
        check("start beats mthi HI", HI, 32'h5A5A);
        check("start beats mthi busy", {31'b0, Busy}, 32'd1);
        wait_done("multu 2*2", 1, WIDTH + 2, 1'b0, 32'h0, 32'h4);

        // Mid-operation asynchronous reset
        @(negedge Clk); MTHI = 1'b1; MTLO = 1'b1; WrData = 32'hA5;
        @(negedge Clk); MTHI = 1'b0; MTLO = 1'b0;
        @(negedge Clk); Start = 1'b1; Op = 2'b10; A = 32'd100; B = 32'd7;
        @(negedge Clk); Start = 1'b0; A = '0; B = '0;
        repeat (10) @(negedge Clk);
        check("busy before reset", {31'b0, Busy}, 32'd1);
        #2 Reset = 1'b0;
        #1;
        check("async reset Busy", {31'b0, Busy}, 32'd0);
        check("async reset Done", {31'b0, Done}, 32'd0);
        check("async reset HI", HI, 32'd0);
        check("async reset LO", LO, 32'd0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        check("after reset Busy", {31'b0, Busy}, 32'd0);
        check("after reset LO", LO, 32'd0);
        run_op("multu 2*3 after reset", 2'b00, 32'd2, 32'd3, 1'b0, 32'h0, 32'h6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle multiply/divide unit with its own sequencer. It owns the HI/LO register pair that the control unit's MFHI/MFLO/MTHI/MTLO signals address. It is launched by MULT/MULTU/DIV/DIVU decode and raises Busy so the core can stall HI/LO accesses until the result is committed. It replaces a combinational 64-bit multiplier/divider with a shift-add / restoring-division engine of WIDTH iterations.

Parameters:
WIDTH, 32, operand width; iteration count of the CALC phase.

Ports:
Clk  input  1  system clock, rising edge.
Reset  input  1  asynchronous, active-low reset.
Start  input  1  launch operation; sampled only in IDLE.
Op  input  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
A  input  WIDTH  multiplicand or dividend (rs), captured on accepted Start.
B  input  WIDTH  multiplier or divisor (rt), captured on accepted Start.
MTHI  input  1  write WrData into HI.
MTLO  input  1  write WrData into LO.
WrData  input  WIDTH  data for MTHI/MTLO.
Busy  output  1  high while an operation is in flight (CALC or FIX).
Done  output  1  one-cycle pulse; HI/LO already hold the result in this cycle.
DivZero  output  1  one-cycle pulse coincident with Done for DIV/DIVU with B==0.
HI  output  WIDTH  HI register (registered output).
LO  output  WIDTH  LO register (registered output).

Behaviour:
- Reset low: state forced to IDLE immediately. HI, LO, Busy, Done, DivZero, the iteration counter and working registers all clear to 0. Reset is honoured mid-operation and aborts it; no partial result is written.
- States: IDLE, CALC, FIX.
  - IDLE→CALC on Start, except DIV/DIVU with B==0.
  - IDLE→FIX on Start for DIV/DIVU with B==0.
  - CALC→FIX after WIDTH iterations; the counter runs 0..WIDTH-1.
  - FIX→IDLE unconditionally.
- Latency: Start accepted at edge t. Busy is high in cycles t+1..t+WIDTH+1. HI/LO are written at the FIX edge. Done is high in cycle t+WIDTH+2 and Busy is low in that cycle. With WIDTH=32, results appear 34 cycles after Start.
- Divide by zero: Busy is high for 1 cycle (FIX). Done and DivZero pulse at t+2. HI and LO are unchanged.
- Signed operations (MULT, DIV):
  - The absolute values of A and B are taken at capture; the engine runs unsigned.
  - FIX applies sign correction.
  - MULT: the 2·WIDTH product is negated if the signs of A and B differ.
  - DIV: the quotient is negated if the signs differ; the remainder takes the sign of the dividend.
- Result mapping:
  - Multiply: HI = upper WIDTH bits, LO = lower WIDTH bits.
  - Divide: LO = quotient, HI = remainder.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (two's-complement wrap, no trap).
- Unsigned engine:
  - Multiply: 2·WIDTH accumulator, right shift-add per cycle.
  - Divide: restoring division, one quotient bit per cycle, MSB first.
- Start while Busy is ignored; operands are not recaptured.
- MTHI/MTLO:
  - Honoured only in IDLE; the write is visible on HI/LO from the next cycle.
  - Ignored while Busy. The core stalls these accesses, and the block does not queue them.
  - MTHI and MTLO together write WrData to both registers.
  - Start together with MTHI/MTLO in IDLE: Start wins and the moves are dropped.
- MFHI/MFLO read the HI/LO outputs directly. A read during Busy returns the previous values; stalling such reads is the core's responsibility.
- Done and DivZero are never high for more than one consecutive cycle.

Test Plan:
1. MULTU A=0xFFFFFFFF B=0xFFFFFFFF → Busy high for 33 cycles; Done at t+34; HI=0xFFFFFFFE, LO=0x00000001.
2. MULT A=0xFFFFFFFD (-3) B=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then MULT A=-3 B=-7 → HI=0, LO=0x15.
3. DIVU A=100 B=7 → LO=0xE, HI=0x2. DIV A=0xFFFFFFF9 (-7) B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
4. Preload HI=0x11, LO=0x22 via MTHI/MTLO, then DIVU A=5 B=0 → Done and DivZero both pulse at t+2; Busy high only in t+1; HI=0x11, LO=0x22 unchanged.
5. Start MULTU 3×4, then during Busy assert MTHI with WrData=0x1234 and a new Start → both are ignored; final HI=0, LO=0xC. In IDLE, MTLO with WrData=0xABCD → LO=0xABCD next cycle.
6. Pull Reset low at iteration 10 of a DIVU → Busy, Done, HI and LO are 0 immediately without a clock edge. After release, a fresh MULTU 2×3 gives LO=6 at t+34.
